servo_sweep_seq: RTL and testbench
==================================

SERVO_SWEEP_SEQ -- requirements
Module: servo_sweep_seq

Parameters
REQ-001 The block SHALL provide these parameters, one per line: name, default, meaning.
- FRAME_TICKS  200  clk_10KHz cycles per PWM frame (20 ms)
- DEB_TICKS    200  cycles the synchronized button level must hold before it is accepted (20 ms)
- MIN_W        7    minimum width code (0.7 ms)
- MAX_W        17   maximum width code (1.7 ms)
- CENTER_W     12   parked width code (1.2 ms)
- HOLD_UNIT    5    frames per hold step

Interface
REQ-002 The block SHALL provide these ports, one per line: name, direction, width, meaning.
- clk_10KHz   in   1  sole clock (0.1 ms period)
- reset       in   1  asynchronous, active-high reset
- enable      in   1  sweep enable, synchronous to clk_10KHz
- btn_speed   in   1  raw asynchronous push-button
- width_code  out  5  pulse width in 0.1 ms units, consumed by the PWM stage
- frame_start out  1  one-cycle strobe on the first cycle of each frame
- speed       out  3  current speed index, 0..7
- dir         out  1  sweep direction: 1 = increasing, 0 = decreasing
- busy        out  1  high while in SWEEP_UP or SWEEP_DOWN

Function
REQ-003 frame_cnt SHALL count 0..FRAME_TICKS-1, wrapping to 0; frame_start = 1 exactly when frame_cnt == 0.
REQ-004 frame_end is defined as frame_cnt == FRAME_TICKS-1.
REQ-005 width_code, dir and the state SHALL change only on the clock edge at frame_end, so width_code is constant across every frame.
REQ-006 btn_speed SHALL pass through a 2-FF synchronizer before any other use.
REQ-007 Debounce: the accepted level SHALL update only after the synchronized level has differed from it for DEB_TICKS consecutive cycles; any mismatch-free cycle clears the debounce counter.
REQ-008 A 0->1 transition of the accepted level with enable = 1 SHALL increment speed modulo 8 (7 -> 0).
REQ-009 A 0->1 transition with enable = 0 SHALL be ignored.
REQ-010 hold_cnt (6-bit) SHALL increment at each frame_end while busy = 1.
REQ-011 A position step SHALL occur at the frame_end where hold_cnt >= HOLD_UNIT*(speed+1)-1; at that edge hold_cnt clears to 0.
REQ-012 The step threshold SHALL use the current speed value. If a speed change lowers the threshold below hold_cnt, the step occurs at the next frame_end.
REQ-013 States SHALL be IDLE, SWEEP_UP and SWEEP_DOWN; all transitions are evaluated at frame_end only.
REQ-014 IDLE: width_code = CENTER_W, dir = 1, hold_cnt = 0. With enable = 1 at frame_end, the block SHALL enter SWEEP_UP.
REQ-015 SWEEP_UP on step: width_code +1. If the new value equals MAX_W, the block SHALL go to SWEEP_DOWN and set dir = 0.
REQ-016 SWEEP_DOWN on step: width_code -1. If the new value equals MIN_W, the block SHALL go to SWEEP_UP and set dir = 1.
REQ-017 width_code SHALL never leave [MIN_W, MAX_W]. Any out-of-range value SHALL be forced to CENTER_W and the state to IDLE.
REQ-018 enable = 0 sampled at frame_end in any sweep state SHALL force IDLE, width_code = CENTER_W, hold_cnt = 0 and dir = 1 at that same edge.
REQ-019 enable = 0 in the middle of a frame SHALL have no effect until frame_end.
REQ-020 If a step and enable = 0 coincide at the same frame_end, enable = 0 SHALL take priority and the block goes to IDLE.
REQ-021 busy SHALL equal 1 in SWEEP_UP or SWEEP_DOWN and 0 in IDLE.

Reset
REQ-022 On reset = 1, asynchronously, the block SHALL set:
- frame_cnt = 0, hold_cnt = 0, debounce counter = 0
- synchronizer and accepted level = 0
- speed = 0, state = IDLE, width_code = CENTER_W, dir = 1, busy = 0
- frame_start = 0 while reset is held
REQ-023 After reset release, frame_start SHALL assert on the first clock edge (frame_cnt == 0 cycle).
REQ-024 Reset asserted mid-sweep or mid-debounce SHALL discard all progress, with no step or speed change pending afterwards.

Verification
REQ-025 Basic sweep: reset, then enable = 1 with speed 0.
- width_code SHALL be 12 for frame 1.
- Then 12 for 5 frames, then 13, 14, ... up to 17 (dir -> 0), then 16 ... 7 (dir -> 1), each value held 5 frames.
REQ-026 Speed step: a clean 30 ms button press (300 cycles) with enable = 1.
- speed 0 -> 1 exactly DEB_TICKS+2 cycles after the synchronized edge.
- Hold becomes 10 frames per step.
REQ-027 Bounce rejection: btn_speed toggling every 5 ms for 50 ms, then low.
- speed SHALL stay unchanged.
- Eight valid presses SHALL wrap speed 7 -> 0.
REQ-028 Disable: enable = 0 mid-frame while width_code = 15.
- width_code SHALL stay 15 until frame_end, then become 12 with busy = 0 and dir = 1.
- Re-enabling SHALL restart the sweep from 12, counting up.
REQ-029 Speed change mid-hold: at speed 7, hold_cnt = 20, press the button so speed becomes 0.
- The step SHALL occur at the next frame_end and hold_cnt SHALL clear.
REQ-030 Async reset: reset pulsed for 1 cycle mid-frame during SWEEP_DOWN.
- Outputs SHALL go immediately to width_code = 12, speed = 0, busy = 0.
- frame_start SHALL fire on the first edge after release.

Source files
------------

// File: rtl/servo_sweep_seq.sv
// servo_sweep_seq: frame-paced servo sweep sequencer.
// A debounced speed button sets how many frames each position is held.
`timescale 1ns/1ps
module servo_sweep_seq #(
  parameter int FRAME_TICKS = 200,
  parameter int DEB_TICKS   = 200,
  parameter int MIN_W       = 7,
  parameter int MAX_W       = 17,
  parameter int CENTER_W    = 12,
  parameter int HOLD_UNIT   = 5
) (
  input  logic       clk_10KHz,
  input  logic       reset,
  input  logic       enable,
  input  logic       btn_speed,
  output logic [4:0] width_code,
  output logic       frame_start,
  output logic [2:0] speed,
  output logic       dir,
  output logic       busy
);

  localparam int FW = $clog2(FRAME_TICKS);
  localparam int DW = $clog2(DEB_TICKS + 1);

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    SWEEP_UP   = 2'd1,
    SWEEP_DOWN = 2'd2
  } state_t;

  state_t        state, state_n;
  logic [FW-1:0] frame_cnt;
  logic          frame_end;
  logic [1:0]    sync;
  logic          acc, acc_d;
  logic [DW-1:0] deb_cnt;
  logic [5:0]    hold_cnt, hold_n;
  logic [4:0]    width_n, w_up, w_dn;
  logic          dir_n;
  logic [6:0]    step_thr;
  logic          step, in_range, sweeping;
  logic          kill, start, hold_go;
  logic          step_up, step_dn;

  assign frame_end = frame_cnt == FW'(FRAME_TICKS - 1);
  assign w_up      = width_code + 5'd1;
  assign w_dn      = width_code - 5'd1;
  assign step_thr  = 7'(HOLD_UNIT * (int'(speed) + 1) - 1);
  assign step      = {1'b0, hold_cnt} >= step_thr;
  assign in_range  = (width_code >= 5'(MIN_W))
                   && (width_code <= 5'(MAX_W));
  assign sweeping  = (state == SWEEP_UP)
                   || (state == SWEEP_DOWN);
  assign kill      = !enable || !in_range;
  assign start     = !kill && (state == IDLE);
  assign hold_go   = !kill && sweeping && !step;
  assign step_up   = !kill && (state == SWEEP_UP) && step;
  assign step_dn   = !kill && (state == SWEEP_DOWN) && step;

  // frame timebase: free-running 0..FRAME_TICKS-1
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) frame_cnt <= '0;
    else if (frame_end) frame_cnt <= '0;
    else frame_cnt <= frame_cnt + FW'(1);
  end

  // button sync, debounce and speed select on accepted rising edge
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      sync    <= '0;
      acc     <= 1'b0;
      acc_d   <= 1'b0;
      deb_cnt <= '0;
      speed   <= '0;
    end else begin
      sync  <= {sync[0], btn_speed};
      acc_d <= acc;
      if (sync[1] == acc) begin
        deb_cnt <= '0;
      end else if (deb_cnt == DW'(DEB_TICKS)) begin
        acc     <= sync[1];
        deb_cnt <= '0;
      end else begin
        deb_cnt <= deb_cnt + DW'(1);
      end
      if (acc && !acc_d && enable) speed <= speed + 3'd1;
    end
  end

  // sweep state and position registers, updated on frame edges only
  always_ff @(posedge clk_10KHz or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      width_code <= 5'(CENTER_W);
      dir        <= 1'b1;
      hold_cnt   <= '0;
    end else begin
      state      <= state_n;
      width_code <= width_n;
      dir        <= dir_n;
      hold_cnt   <= hold_n;
    end
  end

  // next sweep state; a disable or bad width always wins over a step
  always_comb begin
    state_n = state;
    width_n = width_code;
    dir_n   = dir;
    hold_n  = hold_cnt;
    if (frame_end) begin
      unique case (1'b1)
        kill: begin
          state_n = IDLE;
          width_n = 5'(CENTER_W);
          dir_n   = 1'b1;
          hold_n  = '0;
        end
        start: begin
          state_n = SWEEP_UP;
          width_n = 5'(CENTER_W);
          dir_n   = 1'b1;
          hold_n  = '0;
        end
        hold_go: hold_n = hold_cnt + 6'd1;
        step_up: begin
          hold_n  = '0;
          width_n = w_up;
          if (w_up == 5'(MAX_W)) begin
            state_n = SWEEP_DOWN;
            dir_n   = 1'b0;
          end
        end
        step_dn: begin
          hold_n  = '0;
          width_n = w_dn;
          if (w_dn == 5'(MIN_W)) begin
            state_n = SWEEP_UP;
            dir_n   = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          width_n = 5'(CENTER_W);
          dir_n   = 1'b1;
          hold_n  = '0;
        end
      endcase
    end
  end

  // status outputs; no frame strobe while reset is held
  always_comb begin
    busy        = sweeping;
    frame_start = (frame_cnt == '0) && !reset;
  end

endmodule

// File: tb/tb_servo_sweep_seq.sv
// tb_servo_sweep_seq: directed bench for servo_sweep_seq.
// Timing is tracked as clock edges since the last reset release.
`timescale 1ns/1ps
module tb_servo_sweep_seq;

  logic       clk_10KHz = 1'b0;
  logic       reset     = 1'b1;
  logic       enable    = 1'b0;
  logic       btn_speed = 1'b0;
  logic [4:0] width_code;
  logic       frame_start;
  logic [2:0] speed;
  logic       dir;
  logic       busy;

  int cyc;
  int n_chk;
  int n_pass;
  int exp_w[$];
  int exp_d[$];
  int e0;

  servo_sweep_seq dut (
    .clk_10KHz   (clk_10KHz),
    .reset       (reset),
    .enable      (enable),
    .btn_speed   (btn_speed),
    .width_code  (width_code),
    .frame_start (frame_start),
    .speed       (speed),
    .dir         (dir),
    .busy        (busy)
  );

  always #5 clk_10KHz = ~clk_10KHz;

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s @cyc %0d: got %0d expected %0d",
                  tag, cyc, got, exp);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_10KHz);
      cyc++;
    end
    #1;
  endtask

  task automatic go(input int c);
    if (c > cyc) tick(c - cyc);
  endtask

  task automatic do_reset(input logic en);
    @(posedge clk_10KHz);
    #1;
    reset     = 1'b1;
    enable    = en;
    btn_speed = 1'b0;
    #1;
    chk("rst_width", width_code, 12);
    chk("rst_speed", speed, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dir", dir, 1);
    chk("rst_fs", frame_start, 0);
    tick(2);
    #2;
    reset = 1'b0;
    cyc   = 0;
    #1;
    chk("rel_fs", frame_start, 1);
  endtask

  task automatic press(input int hi, input int lo);
    btn_speed = 1'b1;
    tick(hi);
    btn_speed = 1'b0;
    tick(lo);
  endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    cyc    = 0;

    // reset state and frame strobe cadence
    do_reset(1'b0);
    tick(1);
    chk("fs_c1", frame_start, 0);
    go(199);
    chk("fs_c199", frame_start, 0);
    go(200);
    chk("fs_c200", frame_start, 1);
    go(201);
    chk("fs_c201", frame_start, 0);
    go(400);
    chk("idle_busy", busy, 0);

    // basic sweep at speed 0
    for (int i = 0; i < 6; i++) begin
      exp_w.push_back(12); exp_d.push_back(1);
    end
    for (int w = 13; w <= 17; w++)
      for (int i = 0; i < 5; i++) begin
        exp_w.push_back(w); exp_d.push_back(w == 17 ? 0 : 1);
      end
    for (int w = 16; w >= 7; w--)
      for (int i = 0; i < 5; i++) begin
        exp_w.push_back(w); exp_d.push_back(w == 7 ? 1 : 0);
      end
    for (int w = 8; w <= 9; w++)
      for (int i = 0; i < 5; i++) begin
        exp_w.push_back(w); exp_d.push_back(1);
      end
    do_reset(1'b1);
    for (int f = 0; f < exp_w.size(); f++) begin
      go(200 * f + 100);
      chk("sweep_w", width_code, exp_w[f]);
      chk("sweep_dir", dir, exp_d[f]);
      chk("sweep_busy", busy, f > 0 ? 1 : 0);
    end

    // disable mid-frame at width 15, then re-enable
    do_reset(1'b1);
    go(3500);
    chk("dis_pre_w", width_code, 15);
    enable = 1'b0;
    go(3599);
    chk("dis_hold_w", width_code, 15);
    chk("dis_hold_busy", busy, 1);
    go(3600);
    chk("dis_w", width_code, 12);
    chk("dis_busy", busy, 0);
    chk("dis_dir", dir, 1);
    go(3700);
    enable = 1'b1;
    go(3800);
    chk("reen_busy", busy, 1);
    go(4799);
    chk("reen_w12", width_code, 12);
    go(4800);
    chk("reen_w13", width_code, 13);
    chk("reen_dir", dir, 1);

    // clean press: exact debounce latency, then 10-frame hold
    do_reset(1'b1);
    btn_speed = 1'b1;
    go(203);
    chk("spd_pre", speed, 0);
    go(204);
    chk("spd_post", speed, 1);
    go(300);
    btn_speed = 1'b0;
    go(2199);
    chk("spd1_w12", width_code, 12);
    go(2200);
    chk("spd1_w13", width_code, 13);
    go(4199);
    chk("spd1_w13b", width_code, 13);
    go(4200);
    chk("spd1_w14", width_code, 14);
    chk("spd1_keep", speed, 1);

    // press while disabled is ignored
    do_reset(1'b0);
    press(300, 300);
    chk("dis_press_spd", speed, 0);
    chk("dis_press_busy", busy, 0);

    // bounce rejection, then seven clean presses
    do_reset(1'b1);
    for (int i = 0; i < 10; i++) begin
      btn_speed = (i % 2 == 0);
      tick(50);
    end
    btn_speed = 1'b0;
    tick(400);
    chk("bounce_spd", speed, 0);
    for (int i = 1; i <= 7; i++) begin
      press(250, 250);
      chk("press_spd", speed, i);
    end

    // speed 7 -> 0 wrap with hold_cnt at 20: step at next frame edge
    e0 = (cyc / 200 + 1) * 200 + 100;
    go(e0);
    enable = 1'b0;
    go(e0 + 100);
    chk("align_busy", busy, 0);
    chk("align_w", width_code, 12);
    go(e0 + 200);
    enable = 1'b1;
    e0 = e0 + 300;
    go(e0);
    chk("align_run", busy, 1);
    go(e0 + 3900);
    btn_speed = 1'b1;
    go(e0 + 4103);
    chk("wrap_pre", speed, 7);
    go(e0 + 4104);
    chk("wrap_spd", speed, 0);
    go(e0 + 4199);
    chk("mid_w12", width_code, 12);
    go(e0 + 4200);
    chk("mid_w13", width_code, 13);
    btn_speed = 1'b0;
    go(e0 + 5199);
    chk("mid_w13b", width_code, 13);
    go(e0 + 5200);
    chk("mid_w14", width_code, 14);

    // async reset pulse during SWEEP_DOWN
    do_reset(1'b1);
    btn_speed = 1'b1;
    go(300);
    btn_speed = 1'b0;
    go(12300);
    chk("down_w", width_code, 16);
    chk("down_dir", dir, 0);
    chk("down_busy", busy, 1);
    chk("down_spd", speed, 1);
    #3;
    reset = 1'b1;
    #1;
    chk("ar_w", width_code, 12);
    chk("ar_spd", speed, 0);
    chk("ar_busy", busy, 0);
    chk("ar_dir", dir, 1);
    chk("ar_fs", frame_start, 0);
    tick(1);
    #3;
    reset = 1'b0;
    cyc   = 0;
    #1;
    chk("ar_rel_fs", frame_start, 1);
    tick(1);
    chk("ar_fs_c1", frame_start, 0);
    go(1199);
    chk("ar_w12", width_code, 12);
    chk("ar_run", busy, 1);
    go(1200);
    chk("ar_w13", width_code, 13);
    chk("ar_spd0", speed, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
